// File: rtl/fc_requant_serializer.sv
// Requantizes a parallel FC accumulator vector and streams it one element
// per cycle into the serial input of the next FC layer.
`timescale 1ns/1ps
module fc_requant_serializer #(
    parameter int NUM_NEURONS = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int RELU_EN     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic signed [ACC_WIDTH-1:0]  fc_in [NUM_NEURONS],
    output logic                         ready_out,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         valid_out,
    output logic                         last_out,
    output logic                         overrun_err
);

    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    localparam logic signed [ACC_WIDTH:0] HALF =
        {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [ACC_WIDTH:0] MAX_S =
        {{(ACC_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MIN_S = ~MAX_S;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                           ovr_q, ovr_d;
    logic signed [DATA_WIDTH-1:0]   buf_q [NUM_NEURONS];
    logic                           accept;

    // One extra bit of headroom so the rounding add never wraps.
    function automatic logic signed [DATA_WIDTH-1:0] requant(
        input logic signed [ACC_WIDTH-1:0] a
    );
        logic signed [ACC_WIDTH:0]     t;
        logic signed [ACC_WIDTH:0]     s;
        logic signed [DATA_WIDTH-1:0]  r;
        t = {a[ACC_WIDTH-1], a} + HALF;
        s = t >>> FRAC_BITS;
        if (RELU_EN != 0 && s[ACC_WIDTH]) begin
            s = '0;
        end
        if (s > MAX_S) begin
            r = MAX_S[DATA_WIDTH-1:0];
        end else if (s < MIN_S) begin
            r = MIN_S[DATA_WIDTH-1:0];
        end else begin
            r = s[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        ovr_d       = ovr_q;
        ready_out   = (state_q == IDLE) ||
                      (state_q == STREAM && idx_q == LAST_IDX);
        accept      = valid_in && ready_out;
        valid_out   = (state_q == STREAM);
        last_out    = valid_out && (idx_q == LAST_IDX);
        data_out    = valid_out ? buf_q[idx_q] : hold_q;
        overrun_err = ovr_q;
        if (valid_out) begin
            hold_d = buf_q[idx_q];
        end
        if (valid_in && !ready_out) begin
            ovr_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 1'b1;
                end else if (accept) begin
                    idx_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                buf_q[k] <= requant(fc_in[k]);
            end
        end
    end

endmodule

// File: tb/tb_fc_requant_serializer.sv
// Random and directed bench for fc_requant_serializer; two instances
// (ReLU on/off) share stimulus and are checked against a queue model.
`timescale 1ns/1ps
module tb_fc_requant_serializer;

    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               valid_in;
    logic signed [31:0] fc_in [N];

    logic        r1, v1, l1, o1;
    logic [15:0] d1;
    logic        r0, v0, l0, o0;
    logic [15:0] d0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    fc_requant_serializer #(
        .NUM_NEURONS(N), .ACC_WIDTH(32), .DATA_WIDTH(16),
        .FRAC_BITS(8), .RELU_EN(1)
    ) u1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .fc_in(fc_in),
        .ready_out(r1), .data_out(d1), .valid_out(v1),
        .last_out(l1), .overrun_err(o1)
    );

    fc_requant_serializer #(
        .NUM_NEURONS(N), .ACC_WIDTH(32), .DATA_WIDTH(16),
        .FRAC_BITS(8), .RELU_EN(0)
    ) u0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .fc_in(fc_in),
        .ready_out(r0), .data_out(d0), .valid_out(v0),
        .last_out(l0), .overrun_err(o0)
    );

    // Model: pending elements per instance, last shown value, sticky overrun.
    logic [15:0] q1 [$];
    logic [15:0] q0 [$];
    logic [15:0] ld1 = '0;
    logic [15:0] ld0 = '0;
    bit          movr = 1'b0;

    function automatic logic [15:0] rq(input logic signed [31:0] a,
                                       input bit relu);
        longint v;
        v = longint'(a) + 128;
        v = v >>> 8;
        if (relu && v < 0) v = 0;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    task automatic model_step();
        bit rdy;
        if (rst) begin
            q1.delete();
            q0.delete();
            ld1 = '0;
            ld0 = '0;
            movr = 1'b0;
        end else begin
            rdy = (q1.size() <= 1);
            if (q1.size() > 0) begin
                ld1 = q1.pop_front();
                ld0 = q0.pop_front();
            end
            if (valid_in && rdy) begin
                for (int k = 0; k < N; k++) begin
                    q1.push_back(rq(fc_in[k], 1'b1));
                    q0.push_back(rq(fc_in[k], 1'b0));
                end
            end else if (valid_in) begin
                movr = 1'b1;
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("u1.valid", 32'(v1), 32'(q1.size() > 0));
            chk("u1.last", 32'(l1), 32'(q1.size() == 1));
            chk("u1.ready", 32'(r1), 32'(q1.size() <= 1));
            chk("u1.data", 32'(d1), 32'(q1.size() > 0 ? q1[0] : ld1));
            chk("u1.ovr", 32'(o1), 32'(movr));
            chk("u0.valid", 32'(v0), 32'(q0.size() > 0));
            chk("u0.last", 32'(l0), 32'(q0.size() == 1));
            chk("u0.ready", 32'(r0), 32'(q0.size() <= 1));
            chk("u0.data", 32'(d0), 32'(q0.size() > 0 ? q0[0] : ld0));
            chk("u0.ovr", 32'(o0), 32'(movr));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && q1.size() != 0; i++) step();
        chk("idle_timeout", 32'(q1.size()), 32'd0);
    endtask

    task automatic rand_vec();
        for (int k = 0; k < N; k++) begin
            case ($urandom % 4)
                0: fc_in[k] = $urandom;
                1: fc_in[k] = int'($urandom_range(0, 1 << 24)) - (1 << 23);
                2: fc_in[k] = ($urandom % 2) ? 32'sh7FFF_FFFF
                                             : 32'sh8000_0000;
                default: fc_in[k] = int'($urandom_range(0, 4095)) - 2048;
            endcase
        end
    endtask

    localparam logic [15:0] E1 [7] = '{16'h0004, 16'h0000, 16'h0000,
        16'h0001, 16'h7FFF, 16'h7FFF, 16'h0000};
    localparam logic [15:0] E0 [7] = '{16'h0004, 16'hFFFD, 16'h0000,
        16'h0001, 16'h7FFF, 16'h7FFF, 16'h8000};

    int nv, nl;
    logic [15:0] orig [N];

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        for (int k = 0; k < N; k++) fc_in[k] = '0;
        step();
        step();
        chk_en = 1'b1;
        chk("rst.valid", 32'(v1), 32'd0);
        chk("rst.ready", 32'(r1), 32'd1);
        chk("rst.data", 32'(d1), 32'd0);
        chk("rst.last", 32'(l1), 32'd0);
        chk("rst.ovr", 32'(o1), 32'd0);
        rst = 1'b0;

        chk("pin.rq896", 32'(rq(896, 1'b1)), 32'd4);
        chk("pin.rqm896", 32'(rq(-896, 1'b0)), 32'h0000FFFD);
        chk("pin.rq127", 32'(rq(127, 1'b1)), 32'd0);

        // Single vector: data k+1, last and ready only on element 15.
        wait_idle();
        for (int k = 0; k < N; k++) fc_in[k] = k * 256 + 128;
        valid_in = 1'b1;
        for (int k = 0; k < N; k++) begin
            step();
            if (k == 0) valid_in = 1'b0;
            chk("t1.data", 32'(d1), 32'(k + 1));
            chk("t1.valid", 32'(v1), 32'd1);
            chk("t1.last", 32'(l1), 32'(k == N - 1));
            chk("t1.ready", 32'(r1), 32'(k == N - 1));
        end
        step();
        chk("t1.idle_valid", 32'(v1), 32'd0);
        chk("t1.idle_ready", 32'(r1), 32'd1);
        chk("t1.hold", 32'(d1), 32'd16);
        chk("t1.idle_last", 32'(l1), 32'd0);

        // Sign, rounding and saturation corners.
        wait_idle();
        for (int k = 0; k < N; k++) fc_in[k] = '0;
        fc_in[0] = 896;
        fc_in[1] = -896;
        fc_in[2] = 127;
        fc_in[3] = 128;
        fc_in[4] = 32'sh0100_0000;
        fc_in[5] = 32'sh7FFF_FFFF;
        fc_in[6] = 32'sh8000_0000;
        valid_in = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            if (k == 0) valid_in = 1'b0;
            chk("t2.relu", 32'(d1), 32'(E1[k]));
            chk("t2.norelu", 32'(d0), 32'(E0[k]));
        end

        // Back-to-back vectors.
        wait_idle();
        rand_vec();
        valid_in = 1'b1;
        nv = 0;
        nl = 0;
        for (int i = 0; i < 2 * N; i++) begin
            step();
            if (i == 0 || i == N) valid_in = 1'b0;
            if (i == N - 1) begin
                rand_vec();
                valid_in = 1'b1;
            end
            nv += int'(v1);
            nl += int'(l1);
        end
        chk("t4.valid_cnt", 32'(nv), 32'd32);
        chk("t4.last_cnt", 32'(nl), 32'd2);
        step();
        chk("t4.after", 32'(v1), 32'd0);

        // Overrun during element 5.
        wait_idle();
        rand_vec();
        for (int k = 0; k < N; k++) orig[k] = rq(fc_in[k], 1'b1);
        valid_in = 1'b1;
        for (int i = 0; i < N; i++) begin
            step();
            if (i == 0 || i == 6) valid_in = 1'b0;
            if (i == 5) begin
                rand_vec();
                valid_in = 1'b1;
            end
            chk("t5.data", 32'(d1), 32'(orig[i]));
        end
        step();
        step();
        chk("t5.ovr", 32'(o1), 32'd1);

        // Reset at element 7, then a fresh vector.
        wait_idle();
        rand_vec();
        valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) valid_in = 1'b0;
        end
        rst = 1'b1;
        step();
        chk("t6.valid", 32'(v1), 32'd0);
        chk("t6.last", 32'(l1), 32'd0);
        chk("t6.data", 32'(d1), 32'd0);
        chk("t6.ready", 32'(r1), 32'd1);
        chk("t6.ovr", 32'(o1), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < N; k++) fc_in[k] = 5 * 256;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        chk("t6.new_valid", 32'(v1), 32'd1);
        chk("t6.new_data", 32'(d1), 32'd5);

        // Random traffic.
        for (int c = 0; c < 2500; c++) begin
            step();
            rst = ($urandom % 400) == 0;
            valid_in = ($urandom % 3) == 0;
            rand_vec();
        end
        rst = 1'b0;
        valid_in = 1'b0;
        for (int c = 0; c < 20; c++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
